// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared widths, length mask helper and reset defaults for the pattern detector
package seq_det_pkg;
   localparam int MAX_W = 64;
   localparam logic [7:0] DEF_PAT = 8'b0000_0110;
   localparam int DEF_LEN = 4;
   function automatic int len_w(input int pat_w);
      return $clog2(pat_w + 1);
   endfunction
   function automatic logic [MAX_W-1:0] mask(input int len);
      return (len >= MAX_W) ? '1 : (MAX_W'(1) << len) - MAX_W'(1);
   endfunction
endpackage

// File: rtl/seq_detector_prog_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear taking priority over increment
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] out
);
   always_ff @(posedge clk or negedge reset)
      if (!reset) out <= '0;
      else out <= clr ? '0 : (inc && !(&out)) ? out + 1'b1 : out;
endmodule

// File: rtl/seq_detector_prog.sv
// seq_detector_prog: runtime-programmable serial pattern detector with overlap, Mealy/Moore output
// and a saturating match counter
module seq_detector_prog import seq_det_pkg::*; #(
   parameter int PAT_W = 8,
   parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(seq_det_pkg::DEF_PAT),
   parameter int DEF_LEN = seq_det_pkg::DEF_LEN,
   parameter int DEF_OVL = 1,
   parameter int MOORE = 0,
   parameter int CNT_W = 8,
   localparam int LEN_W = len_w(PAT_W)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             x,
   input  logic             x_valid,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] cfg_pat,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_ovl,
   input  logic             cnt_clr,
   output logic             z,
   output logic [CNT_W-1:0] match_cnt,
   output logic             busy
);
   logic [PAT_W-1:0] pat, nxt, m;
   logic [PAT_W-2:0] hist;
   logic [LEN_W-1:0] len, fill, cl;
   logic ovl, acc, hit, zr;
   // the oldest history bit only matters as part of nxt, so it is never stored
   assign acc  = x_valid & ~cfg_load;
   assign nxt  = {hist, x};
   assign m    = PAT_W'(mask(int'(len)));
   assign hit  = acc && ({1'b0, fill} + 1'b1 >= {1'b0, len}) && (((nxt ^ pat) & m) == '0);
   assign cl   = (cfg_len == '0 || int'(cfg_len) > PAT_W) ? LEN_W'(PAT_W) : cfg_len;
   assign z    = (MOORE != 0) ? zr : hit;
   assign busy = fill != '0;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         pat  <= DEF_PAT;
         len  <= LEN_W'(DEF_LEN);
         ovl  <= DEF_OVL != 0;
         hist <= '0;
         fill <= '0;
         zr   <= 1'b0;
      end else begin
         zr <= hit;
         if (cfg_load) begin
            pat  <= cfg_pat;
            len  <= cl;
            ovl  <= cfg_ovl;
            hist <= '0;
            fill <= '0;
         end else if (acc) begin
            hist <= (hit && !ovl) ? '0 : nxt[PAT_W-2:0];
            fill <= (hit && !ovl) ? '0 : (fill == len) ? fill : fill + 1'b1;
         end
      end
   sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (hit),
      .clr   (cnt_clr),
      .out   (match_cnt)
   );
endmodule
